// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher: one load edge, then one inverse round per clock while enable is low.
// The plaintext register updates only on the final round and holds until the next completed decryption.
module aes128_decrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [0:127] ciphertext,
  input  logic [0:127] key,
  output logic [0:127] plaintext
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  logic [0:127] state;
  logic [0:127] key_reg;
  logic [3:0]   round;
  logic [0:1407] ks;
  logic [0:127] rk_sel;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant in GF(2^8); covers the 09/0b/0d/0e InvMixColumns coefficients.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [0:1407] expand_key(input logic [0:127] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] o;
    rc = 8'h01;
    o  = '0;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  // InvShiftRows fused with InvSubBytes: row r of column c comes from column (c - r) mod 4.
  function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = inv_sbox(s[8*(4*((c-r+4)%4)+r) +: 8]);
    return o;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[32*c+8 +: 8]  = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[32*c+16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[32*c+24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  // The live key feeds the expansion on the load edge (for rk10); the latched copy is used while running.
  assign ks = expand_key(enable ? key : key_reg);

  always_comb begin
    rk_sel = '0;
    for (int r = 0; r <= 10; r++)
      if (round == 4'(r)) rk_sel = ks[128*r +: 128];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm       <= IDLE;
      state     <= '0;
      key_reg   <= '0;
      round     <= '0;
      plaintext <= '0;
    end else if (enable) begin
      state   <= ciphertext ^ ks[1280 +: 128];
      key_reg <= key;
      round   <= 4'd9;
      fsm     <= RUN;
    end else if (fsm == RUN) begin
      if (round != 4'd0) begin
        state <= inv_mix_columns(inv_shift_sub(state) ^ rk_sel);
        round <= round - 4'd1;
      end else begin
        plaintext <= inv_shift_sub(state) ^ rk_sel;
        fsm       <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_aes128_decrypt.sv
// Scoreboard bench for aes128_decrypt: stimulus queues expected plaintext per cycle, a monitor compares.
module tb_aes128_decrypt;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [0:127] ciphertext = '0;
  logic [0:127] key = '0;
  logic [0:127] plaintext;

  localparam logic [0:127] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] Z_CT    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    int           due;
    logic [0:127] exp;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_fail = 0;
  logic [0:127] last;

  always #5 clk = ~clk;

  aes128_decrypt dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext)
  );

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [0:127] got, input logic [0:127] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: plaintext=%032h required=%032h", name, cyc, got, exp);
    end
  endtask

  task automatic expect_at(input int due, input logic [0:127] v, input string name);
    exp_t e;
    e.due  = due;
    e.exp  = v;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: plaintext is sampled on the falling edge for every entry whose cycle has arrived.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      check(mon_e.name, plaintext, mon_e.exp);
    end
  end

  // One load edge, then 12 low cycles; inputs are scrambled after the load to prove they are not resampled.
  task automatic decrypt(input logic [0:127] ct, input logic [0:127] k, input logic [0:127] exp,
                         input string name, input int hold);
    int l;
    @(negedge clk);
    enable = 1'b1; ciphertext = ct; key = k;
    @(negedge clk);
    enable = 1'b0; ciphertext = ~ct; key = ~k;
    l = cyc;
    expect_at(l + 9, last, {name, "_prev"});
    expect_at(l + 10, exp, name);
    for (int i = 1; i <= hold; i++) expect_at(l + 10 + i, exp, {name, "_hold"});
    last = exp;
    repeat (11 + hold) @(negedge clk);
  endtask

  initial begin
    int l, l2;
    last = '0;
    @(negedge clk);
    check("reset_state", plaintext, '0);
    @(negedge clk);
    reset = 1'b1;

    decrypt(C1_CT, C1_KEY, C1_PT, "fips_c1", 0);
    decrypt(B_CT, B_KEY, B_PT, "fips_appb", 0);
    decrypt(C1_CT, C1_KEY, C1_PT, "b2b_c1", 0);
    decrypt(B_CT, B_KEY, B_PT, "b2b_appb", 0);
    decrypt(Z_CT, '0, '0, "zero_key", 20);

    // Abort: App.B started, C.1 loaded over it after 4 run cycles.
    @(negedge clk);
    enable = 1'b1; ciphertext = B_CT; key = B_KEY;
    @(negedge clk);
    enable = 1'b0;
    l = cyc;
    for (int i = 1; i <= 4; i++) expect_at(l + i, last, "abort_pre");
    repeat (4) @(negedge clk);
    enable = 1'b1; ciphertext = C1_CT; key = C1_KEY;
    @(negedge clk);
    enable = 1'b0; key = B_KEY;
    l2 = cyc;
    for (int i = 1; i <= 9; i++) expect_at(l2 + i, last, "abort_no_appb");
    expect_at(l2 + 10, C1_PT, "abort_c1");
    expect_at(l2 + 11, C1_PT, "abort_c1_hold");
    last = C1_PT;
    repeat (11) @(negedge clk);

    // Asynchronous reset mid-run.
    @(negedge clk);
    enable = 1'b1; ciphertext = B_CT; key = B_KEY;
    @(negedge clk);
    enable = 1'b0;
    check("pre_reset_hold", plaintext, C1_PT);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("reset_async", plaintext, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    l = cyc;
    for (int i = 1; i <= 15; i++) expect_at(l + i, '0, "post_reset_idle");
    last = '0;

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sbq.size());
    $fatal(1, "timeout");
  end

endmodule
